// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter.
// master: the arbiter side (drives grants and the transmitter byte/start).
// slave : the environment side (requesters plus the UART transmitter).
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int uart_size = 8
) ();
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*uart_size-1:0] req_data;
  logic [NUM_REQ-1:0]           req_lock;
  logic [NUM_REQ-1:0]           gnt;
  logic [uart_size-1:0]         tx_data;
  logic                         tx_start;
  logic                         tx_busy;

  modport master (
    input  req, req_data, req_lock, tx_busy,
    output gnt, tx_data, tx_start
  );

  modport slave (
    output req, req_data, req_lock, tx_busy,
    input  gnt, tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte
// requesters. Round-robin pick, latch the winner's byte, pulse tx_start,
// then wait for the transmitter's busy frame to complete before the next
// grant. A missing busy response is abandoned after BUSY_TMO cycles.
// Optional feature macro: UART_ARB_LOCK_EN (owner may keep the transmitter
// for consecutive bytes while it holds req_lock).
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int uart_size = 8,
  parameter int BUSY_TMO  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_tx_arbiter_if.master      bus,
  output logic [1:0]             owner,
  output logic                   tmo_err
);

  localparam int CNT_W = $clog2(BUSY_TMO) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 rr_found;
  logic [1:0]           rr_idx;
  int                   cand;
  logic                 lock_hit;
  logic                 win_valid;
  logic [1:0]           win_idx;
  logic [uart_size-1:0] win_data;

  // Round-robin search starting one past the last owner, wrapping to 0.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = owner;
    cand     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(owner) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!rr_found && ((bus.req >> cand) & NUM_REQ'(1)) != '0) begin
        rr_found = 1'b1;
        rr_idx   = 2'(cand);
      end
    end
  end

`ifdef UART_ARB_LOCK_EN
  // Set by a timeout so the following pick ignores the lock once.
  logic lock_rel;
  assign lock_hit = !lock_rel &&
                    (((bus.req & bus.req_lock) >> owner) & NUM_REQ'(1)) != '0;
`else
  logic unused_lock;
  assign unused_lock = ^bus.req_lock;
  assign lock_hit    = 1'b0;
`endif

  assign win_valid = lock_hit | rr_found;
  assign win_idx   = lock_hit ? owner : rr_idx;

  // Select the winning requester's byte.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (2'(i) == win_idx) win_data = bus.req_data[i*uart_size +: uart_size];
    end
  end

  // Control FSM with registered grant, byte, start and timeout outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.gnt      <= '0;
      bus.tx_data  <= '0;
      bus.tx_start <= 1'b0;
      owner        <= 2'(NUM_REQ - 1);
      tmo_err      <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_rel     <= 1'b0;
`endif
    end else begin
      bus.gnt      <= '0;
      bus.tx_start <= 1'b0;
      tmo_err      <= 1'b0;
      case (state)
        IDLE: begin
          // A busy transmitter (someone else's frame) blocks any grant.
          if (win_valid && !bus.tx_busy) begin
            bus.gnt     <= NUM_REQ'(1) << win_idx;
            bus.tx_data <= win_data;
            owner       <= win_idx;
`ifdef UART_ARB_LOCK_EN
            lock_rel    <= 1'b0;
`endif
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          bus.tx_start <= 1'b1;
          cnt          <= '0;
          state        <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_W'(BUSY_TMO - 1)) begin
            // Transmitter never answered: drop the byte, no retry.
            tmo_err <= 1'b1;
`ifdef UART_ARB_LOCK_EN
            lock_rel <= 1'b1;
`endif
            state   <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small transmitter model.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 2;
  localparam int W       = 8;
  localparam int TMO     = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] owner;
  logic       tmo_err;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .uart_size(W)) bif ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .uart_size(W), .BUSY_TMO(TMO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif),
    .owner   (owner),
    .tmo_err (tmo_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Transmitter model: after tx_start, busy for busy_len cycles.
  logic force_busy = 1'b0;
  logic model_en   = 1'b0;
  logic model_busy;
  int   busy_len   = 4;
  int   bcnt;

  assign bif.tx_busy = force_busy | model_busy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_busy <= 1'b0;
      bcnt       <= 0;
    end else if (model_en && bif.tx_start) begin
      model_busy <= 1'b1;
      bcnt       <= busy_len - 1;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
    end else begin
      model_busy <= 1'b0;
    end
  end

  task automatic wait_gnt(input int max, output int cyc);
    cyc = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bif.gnt != '0) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Wait for the current frame to end, then settle back into IDLE.
  task automatic drain();
    logic saw;
    logic done;
    saw  = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bif.tx_busy) saw = 1'b1;
      else if (saw) begin
        done = 1'b1;
        break;
      end
    end
    n_tot++;
    if (!done) $display("FAIL drain: frame end seen=%0b required=1", done);
    else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bif.req = '0; bif.req_data = '0; bif.req_lock = '0;
    repeat (3) @(negedge clk);
    n_tot++; if (bif.gnt !== 2'b00) $display("FAIL rst_gnt: got %b required 00", bif.gnt); else n_pass++;
    n_tot++; if (bif.tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h required 00", bif.tx_data); else n_pass++;
    n_tot++; if (bif.tx_start !== 1'b0) $display("FAIL rst_tx_start: got %b required 0", bif.tx_start); else n_pass++;
    n_tot++; if (owner !== 2'd1) $display("FAIL rst_owner: got %0d required 1", owner); else n_pass++;
    n_tot++; if (tmo_err !== 1'b0) $display("FAIL rst_tmo_err: got %b required 0", tmo_err); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic early;
    logic seen;
    int   k;
    model_en = 1'b1;
    busy_len = 160;
    bif.req_data = {8'h00, 8'h5A};
    bif.req = 2'b01;
    @(negedge clk);
    n_tot++; if (bif.gnt !== 2'b01) $display("FAIL single_gnt: got %b required 01", bif.gnt); else n_pass++;
    n_tot++; if (bif.tx_data !== 8'h5A) $display("FAIL single_data: got %h required 5a", bif.tx_data); else n_pass++;
    n_tot++; if (owner !== 2'd0) $display("FAIL single_owner: got %0d required 0", owner); else n_pass++;
    n_tot++; if (bif.tx_start !== 1'b0) $display("FAIL single_start_early: got %b required 0", bif.tx_start); else n_pass++;
    bif.req = 2'b00;
    @(negedge clk);
    n_tot++; if (bif.tx_start !== 1'b1) $display("FAIL single_start: got %b required 1", bif.tx_start); else n_pass++;
    n_tot++; if (bif.gnt !== 2'b00) $display("FAIL single_gnt_pulse: got %b required 00", bif.gnt); else n_pass++;
    @(negedge clk);
    n_tot++; if (bif.tx_start !== 1'b0) $display("FAIL single_start_pulse: got %b required 0", bif.tx_start); else n_pass++;
    // Queue a second byte while the frame is in flight.
    bif.req_data = {8'h00, 8'h3C};
    bif.req = 2'b01;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bif.tx_busy) seen = 1'b1;
      else @(negedge clk);
    end
    n_tot++; if (!seen) $display("FAIL single_busy_rise: got %b required 1", seen); else n_pass++;
    early = 1'b0;
    for (int i = 0; i < 300 && bif.tx_busy; i++) begin
      if (bif.gnt != '0) early = 1'b1;
      @(negedge clk);
    end
    n_tot++; if (early !== 1'b0) $display("FAIL single_gnt_during_busy: got %b required 0", early); else n_pass++;
    k = 0;
    while (bif.gnt == '0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_tot++; if (k != 2) $display("FAIL single_regrant_gap: got %0d cycles required 2", k); else n_pass++;
    n_tot++; if (bif.tx_data !== 8'h3C) $display("FAIL single_data2: got %h required 3c", bif.tx_data); else n_pass++;
    bif.req = 2'b00;
    drain();
  endtask

  task automatic test_contention();
    int       order [4];
    logic [7:0] dat [4];
    int       exp_order [4] = '{0, 1, 0, 1};
    logic [7:0] exp_dat [4] = '{8'hA1, 8'hB2, 8'hA1, 8'hB2};
    int       ng;
    int       multi;
    pulse_reset();
    busy_len = 4;
    model_en = 1'b1;
    bif.req_data = {8'hB2, 8'hA1};
    bif.req = 2'b11;
    ng = 0;
    multi = 0;
    for (int i = 0; i < 4; i++) begin order[i] = -1; dat[i] = 8'h00; end
    for (int i = 0; i < 400 && ng < 4; i++) begin
      @(negedge clk);
      if ($countones(bif.gnt) > 1) multi++;
      if (bif.gnt != '0) begin
        order[ng] = bif.gnt[1] ? 1 : 0;
        dat[ng]   = bif.tx_data;
        ng++;
      end
    end
    bif.req = 2'b00;
    n_tot++; if (ng != 4) $display("FAIL cont_count: got %0d grants required 4", ng); else n_pass++;
    n_tot++; if (multi != 0) $display("FAIL cont_onehot: got %0d multi-grant cycles required 0", multi); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_tot++;
      if (order[i] != exp_order[i]) $display("FAIL cont_order[%0d]: got %0d required %0d", i, order[i], exp_order[i]);
      else n_pass++;
      n_tot++;
      if (dat[i] !== exp_dat[i]) $display("FAIL cont_data[%0d]: got %h required %h", i, dat[i], exp_dat[i]);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_timeout();
    int c;
    int t;
    model_en = 1'b0;
    bif.req_data = {8'hC7, 8'h00};
    bif.req = 2'b10;
    wait_gnt(20, c);
    n_tot++; if (bif.gnt !== 2'b10) $display("FAIL tmo_gnt: got %b required 10", bif.gnt); else n_pass++;
    n_tot++; if (bif.tx_data !== 8'hC7) $display("FAIL tmo_data: got %h required c7", bif.tx_data); else n_pass++;
    @(negedge clk);
    n_tot++; if (bif.tx_start !== 1'b1) $display("FAIL tmo_start: got %b required 1", bif.tx_start); else n_pass++;
    t = 0;
    while (!tmo_err && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_tot++; if (t != TMO) $display("FAIL tmo_delay: got %0d cycles required %0d", t, TMO); else n_pass++;
    n_tot++; if (owner !== 2'd1) $display("FAIL tmo_owner: got %0d required 1", owner); else n_pass++;
    @(negedge clk);
    n_tot++; if (tmo_err !== 1'b0) $display("FAIL tmo_pulse: got %b required 0", tmo_err); else n_pass++;
    n_tot++; if (bif.gnt !== 2'b10) $display("FAIL tmo_regrant: got %b required 10", bif.gnt); else n_pass++;
    bif.req = 2'b00;
    t = 0;
    while (!tmo_err && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_tot++; if (tmo_err !== 1'b1) $display("FAIL tmo_second: got %b required 1", tmo_err); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int c;
    model_en = 1'b1;
    busy_len = 50;
    bif.req_data = {8'h00, 8'h11};
    bif.req = 2'b01;
    wait_gnt(20, c);
    n_tot++; if (bif.gnt !== 2'b01) $display("FAIL mid_gnt: got %b required 01", bif.gnt); else n_pass++;
    bif.req = 2'b00;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_tot++; if (bif.gnt !== 2'b00) $display("FAIL mid_rst_gnt: got %b required 00", bif.gnt); else n_pass++;
    n_tot++; if (bif.tx_data !== 8'h00) $display("FAIL mid_rst_data: got %h required 00", bif.tx_data); else n_pass++;
    n_tot++; if (bif.tx_start !== 1'b0) $display("FAIL mid_rst_start: got %b required 0", bif.tx_start); else n_pass++;
    n_tot++; if (owner !== 2'd1) $display("FAIL mid_rst_owner: got %0d required 1", owner); else n_pass++;
    n_tot++; if (tmo_err !== 1'b0) $display("FAIL mid_rst_tmo: got %b required 0", tmo_err); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    busy_len = 4;
    bif.req_data = {8'hB2, 8'hA1};
    bif.req = 2'b11;
    wait_gnt(20, c);
    n_tot++; if (bif.gnt !== 2'b01) $display("FAIL mid_first_gnt: got %b required 01", bif.gnt); else n_pass++;
    n_tot++; if (bif.tx_data !== 8'hA1) $display("FAIL mid_first_data: got %h required a1", bif.tx_data); else n_pass++;
    bif.req = 2'b00;
    drain();
  endtask

  task automatic test_lock();
    int order [4];
`ifdef UART_ARB_LOCK_EN
    int exp_order [4] = '{0, 0, 0, 1};
`else
    int exp_order [4] = '{0, 1, 0, 1};
`endif
    int ng;
    int sent0;
    pulse_reset();
    busy_len = 4;
    model_en = 1'b1;
    bif.req_data = {8'h20, 8'h10};
    bif.req_lock = 2'b01;
    bif.req = 2'b11;
    ng = 0;
    sent0 = 0;
    for (int i = 0; i < 4; i++) order[i] = -1;
    for (int i = 0; i < 400 && ng < 4; i++) begin
      @(negedge clk);
      if (bif.gnt != '0) begin
        order[ng] = bif.gnt[1] ? 1 : 0;
        ng++;
        if (bif.gnt[0]) begin
          sent0++;
          if (sent0 == 3) begin
            bif.req[0]      = 1'b0;
            bif.req_lock[0] = 1'b0;
          end else begin
            bif.req_data[7:0] = bif.req_data[7:0] + 8'h01;
          end
        end
      end
    end
    bif.req = 2'b00;
    bif.req_lock = 2'b00;
    for (int i = 0; i < 4; i++) begin
      n_tot++;
      if (order[i] != exp_order[i]) $display("FAIL lock_order[%0d]: got %0d required %0d", i, order[i], exp_order[i]);
      else n_pass++;
    end
    drain();
  endtask

  task automatic test_busy_idle();
    logic early;
    model_en = 1'b1;
    busy_len = 4;
    force_busy = 1'b1;
    bif.req_data = {8'h00, 8'h77};
    bif.req = 2'b01;
    early = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bif.gnt != '0) early = 1'b1;
    end
    n_tot++; if (early !== 1'b0) $display("FAIL busy_idle_nogrant: got %b required 0", early); else n_pass++;
    force_busy = 1'b0;
    @(negedge clk);
    n_tot++; if (bif.gnt !== 2'b01) $display("FAIL busy_idle_gnt: got %b required 01", bif.gnt); else n_pass++;
    n_tot++; if (bif.tx_data !== 8'h77) $display("FAIL busy_idle_data: got %h required 77", bif.tx_data); else n_pass++;
    bif.req = 2'b00;
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_lock();
    test_busy_idle();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between `NUM_REQ` byte requesters, for example the CPU store path and the debug monitor. Selects one requester round-robin, latches its byte, and pulses the transmitter start. Waits for the transmitter's busy cycle to finish before granting again. Sits between the requester ports and the transmitter, on the system clock.

## Interface
- `NUM_REQ`, 2, number of requesters (legal 2..4).
- `uart_size`, 8, byte width.
- `BUSY_TMO`, 64, clk cycles allowed between `tx_start` and `tx_busy` rising.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset: asynchronous, active-low.
- `req`  in  NUM_REQ  per-requester request level.
- `req_data`  in  NUM_REQ*uart_size  requester i byte at bits [i*uart_size +: uart_size].
- `req_lock`  in  NUM_REQ  hold ownership for the next byte (used only with the macro).
- `gnt`  out  NUM_REQ  one-hot, one-cycle pulse: the byte of that requester has been accepted.
- `tx_data`  out  uart_size  byte presented to the transmitter.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_busy`  in  1  transmitter busy, high for the whole frame.
- `owner`  out  2  index of the last or current granted requester.
- `tmo_err`  out  1  one-cycle pulse when `BUSY_TMO` expires.

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE. Reset state is IDLE.
- **IDLE**, when `req` is non-zero and `tx_busy` is 0:
  - Pick the winner by round-robin, searching from `owner+1` upward and wrapping at `NUM_REQ-1` to 0.
  - Register `tx_data` from the winner's `req_data`, set `owner`, pulse `gnt[winner]`, go to ISSUE.
- **IDLE**, when `tx_busy` is already 1: stay in IDLE and grant nothing.
- **ISSUE**: `tx_start`=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
- **WAIT_BUSY**:
  - `tx_busy`=1 → WAIT_DONE.
  - Otherwise the counter increments. When it reaches `BUSY_TMO-1`, pulse `tmo_err` and go to IDLE. The byte is dropped and not retried.
- **WAIT_DONE**: `tx_busy`=0 → IDLE.
- Requester protocol:
  - Hold `req` and `req_data` stable until `gnt` is seen.
  - Deassert `req`, or present the next byte, the cycle after `gnt`.
  - A `req` dropped before its grant has no effect.
- `tx_data` holds its value from the grant until the next grant.
- Counter is `clog2(BUSY_TMO)+1` bits wide and saturates; it never wraps.
- `gnt` is never asserted for more than one requester at a time, nor for more than one cycle per byte.
- Reset while the FSM is mid-operation: the FSM returns to IDLE immediately and all outputs return to their reset values. The pending byte is lost.
- Simultaneous requests: exactly one grant per IDLE pass. Losers keep requesting and win in rotation.

## Timing
- Reset values: `gnt`=0, `tx_data`=0, `tx_start`=0, `owner`=`NUM_REQ-1` (so requester 0 wins first), `tmo_err`=0.
- `req` sampled high at edge N (FSM in IDLE): `gnt` and `tx_data` are valid in cycle N+1; `tx_start` is high in cycle N+2.
- After `tx_busy` falls at edge M: the FSM is in IDLE in cycle M+1, and the earliest next `gnt` is at M+2.
- The round-robin pointer (`owner`) updates only on grant.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - In IDLE, if `req_lock[owner]` and `req[owner]` are both high, the current owner is granted again, bypassing round-robin. Used for multi-byte packets.
  - Lock is sampled in IDLE only.
  - A timeout releases the lock for one pass: the next pick is round-robin.
- `UART_ARB_LOCK_EN` undefined: `req_lock` is ignored and the arbiter is pure round-robin.

## Test plan
- **Single requester:** reset, then `req`=01 with byte 0x5A.
  - Expect `gnt`=01 for one cycle, `tx_data`=0x5A, then `tx_start` one cycle later.
  - Bench model drives `tx_busy` high for 160 cycles.
  - Next grant no earlier than 2 cycles after `tx_busy` falls.
- **Contention:** `req`=11 held, bytes 0xA1 and 0xB2.
  - Expect grant order 0,1,0,1; `tx_data` sequence 0xA1,0xB2,0xA1,0xB2.
  - Never more than one `gnt` bit high.
- **Timeout:** `req`=10, transmitter model never raises `tx_busy`.
  - Expect `tmo_err` exactly `BUSY_TMO` cycles after `tx_start`, the FSM back in IDLE, and requester 1 re-granted.
- **Reset mid-frame:** assert `rst` low during WAIT_DONE.
  - All outputs return to reset values asynchronously.
  - After release, with `req`=11, the first grant goes to requester 0.
- **Lock (`UART_ARB_LOCK_EN`):**
  - Requester 0 has `req_lock`=1 and sends 3 bytes while requester 1 is requesting: expect grants 0,0,0, then 1 after the lock drops.
  - Same stimulus without the macro: expect grants 0,1,0.
- **Busy at idle:** `tx_busy` held high externally while `req`=01.
  - No `gnt` is issued until `tx_busy` goes to 0.
